// File: rtl/load_store_queue.sv
// Circular load/store queue between dispatch and the memory stage.
// Entries are allocated in program order and updated by the memory stage.
// They retire in order at commit. A committed store is written to data memory
// through a req/ack handshake before its entry is released.
//
// Packed entry layout, MSB first (used for i/o of upd_entry and lsq):
//   valid | is_store | ready | color[31:0] | tag[31:0] | address[ADDR_W-1:0] | value[DATA_W-1:0]
module load_store_queue #(
    parameter  int LSQ_SIZE = 16,
    parameter  int ADDR_W   = 64,
    parameter  int DATA_W   = 64,
    localparam int IDX_W    = $clog2(LSQ_SIZE),
    localparam int ENTRY_W  = 3 + 32 + 32 + ADDR_W + DATA_W
) (
    input  logic                        clk,
    input  logic                        reset,
    // dispatch side
    input  logic                        alloc_valid,
    input  logic                        alloc_is_store,
    input  logic [31:0]                 alloc_tag,
    output logic                        alloc_ready,
    // memory stage update
    input  logic [31:0]                 upd_pointer,
    input  logic [ENTRY_W-1:0]          upd_entry,
    // commit side
    input  logic                        commit_valid,
    input  logic [31:0]                 commit_tag,
    output logic                        commit_done,
    input  logic                        flush,
    // data memory write port
    output logic                        dmem_req,
    output logic [ADDR_W-1:0]           dmem_addr,
    output logic [DATA_W-1:0]           dmem_wdata,
    input  logic                        dmem_ack,
    // queue view for the memory stage
    output logic [LSQ_SIZE*ENTRY_W-1:0] lsq,
    output logic [31:0]                 lsq_head,
    output logic [31:0]                 lsq_tail,
    output logic [31:0]                 lsq_count
);

    typedef struct packed {
        logic              valid;
        logic              is_store;
        logic              ready;
        logic [31:0]       color;
        logic [31:0]       tag;
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] value;
    } lsq_entry_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ST_REQ = 2'd1,
        RETIRE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t            r_state;
    state_t            w_state_next;
    lsq_entry_t        r_lsq [LSQ_SIZE];
    logic [IDX_W-1:0]  r_head;
    logic [IDX_W-1:0]  r_tail;
    logic [IDX_W:0]    r_count;
    logic [31:0]       r_color;
    logic              r_dmem_req;
    logic [ADDR_W-1:0] r_dmem_addr;
    logic [DATA_W-1:0] r_dmem_wdata;

    // ------------------------------------------------------------------
    // Decoded control
    // ------------------------------------------------------------------
    lsq_entry_t        w_upd;
    logic              w_unused_upd;
    logic              w_full;
    logic              w_commit_hit;
    logic              w_start;
    logic              w_do_alloc;
    logic              w_upd_in_range;
    logic [IDX_W-1:0]  w_upd_idx;
    logic              w_do_upd;
    logic              w_flush_all;
    logic              w_flush_keep;
    logic              w_retire;

    assign w_upd = upd_entry;
    // The memory stage never changes identity fields; they are ignored here.
    assign w_unused_upd = ^{w_upd.valid, w_upd.is_store, w_upd.color, w_upd.tag};

    assign w_full = (r_count == (IDX_W+1)'(LSQ_SIZE));

    // Head op is committable only once the memory stage marked it ready.
    assign w_commit_hit = commit_valid
                       && r_lsq[r_head].valid
                       && r_lsq[r_head].ready
                       && (r_lsq[r_head].tag == commit_tag);

    // A flush in IDLE squashes everything, including a commit request
    // arriving in the same cycle.
    assign w_start      = (r_state == IDLE) && !flush && w_commit_hit;
    assign w_flush_all  = flush && (r_state == IDLE);
    // Once a commit is underway the head op is architectural and survives.
    assign w_flush_keep = flush && (r_state != IDLE);
    assign w_retire     = (r_state == RETIRE);

    assign w_do_alloc = alloc_valid && !w_full && !flush;

    // upd_pointer is 1-indexed; 0 means no update this cycle.
    assign w_upd_in_range = (upd_pointer != 32'd0) && (upd_pointer <= 32'(LSQ_SIZE));
    assign w_upd_idx      = IDX_W'(upd_pointer - 32'd1);
    assign w_do_upd       = !flush && w_upd_in_range && r_lsq[w_upd_idx].valid;

    // ------------------------------------------------------------------
    // Commit FSM
    // ------------------------------------------------------------------
    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of every other register.
            r_state <= w_state_next;
        end
    end

    // Next-state logic: loads retire directly, stores wait for the write ack.
    always_comb begin
        // NOTE: defaulting first keeps every path assigned, so no latch.
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_next = r_lsq[r_head].is_store ? ST_REQ : RETIRE;
                end
            end
            ST_REQ: begin
                if (dmem_ack) begin
                    w_state_next = RETIRE;
                end
            end
            RETIRE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Queue storage
    // ------------------------------------------------------------------
    // Allocate, update, flush and retire; later statements take precedence.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: this array is reset on purpose: valid/ready bits must come
            // up cleared, and the memory stage sees every field directly.
            for (int i = 0; i < LSQ_SIZE; i++) begin
                r_lsq[i] <= '0;
            end
        end else if (w_flush_all) begin
            for (int i = 0; i < LSQ_SIZE; i++) begin
                r_lsq[i] <= '0;
            end
        end else begin
            if (w_do_alloc) begin
                r_lsq[r_tail] <= '{valid:    1'b1,
                                   is_store: alloc_is_store,
                                   ready:    1'b0,
                                   color:    r_color,
                                   tag:      alloc_tag,
                                   address:  '0,
                                   value:    '0};
            end
            if (w_do_upd) begin
                r_lsq[w_upd_idx].address <= w_upd.address;
                r_lsq[w_upd_idx].value   <= w_upd.value;
                r_lsq[w_upd_idx].ready   <= w_upd.ready;
            end
            if (w_flush_keep) begin
                for (int i = 0; i < LSQ_SIZE; i++) begin
                    if (IDX_W'(i) != r_head) begin
                        r_lsq[i] <= '0;
                    end
                end
            end
            if (w_retire) begin
                r_lsq[r_head] <= '0;
            end
        end
    end

    // Head/tail/count bookkeeping; count disambiguates head==tail.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (w_flush_all) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_retire) begin
                r_head <= r_head + IDX_W'(1);
            end
            if (w_flush_keep) begin
                // Only the committing head survives; it may retire this edge.
                r_tail  <= r_head + IDX_W'(1);
                r_count <= w_retire ? '0 : (IDX_W+1)'(1);
            end else begin
                if (w_do_alloc) begin
                    r_tail <= r_tail + IDX_W'(1);
                end
                r_count <= r_count + (IDX_W+1)'(w_do_alloc) - (IDX_W+1)'(w_retire);
            end
        end
    end

    // Allocation color: monotonic and never reset by flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_color <= 32'd1;
        end else if (w_do_alloc) begin
            r_color <= r_color + 32'd1;
        end
    end

    // Store write port: capture the head store at commit, hold until acked.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dmem_req   <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
        end else if (w_start && r_lsq[r_head].is_store) begin
            r_dmem_req   <= 1'b1;
            r_dmem_addr  <= r_lsq[r_head].address;
            r_dmem_wdata <= r_lsq[r_head].value;
        end else if ((r_state == ST_REQ) && dmem_ack) begin
            r_dmem_req   <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    for (genvar g = 0; g < LSQ_SIZE; g++) begin : g_lsq_out
        assign lsq[g*ENTRY_W +: ENTRY_W] = r_lsq[g];
    end

    assign alloc_ready = !w_full;
    assign commit_done = (r_state == RETIRE);
    assign dmem_req    = r_dmem_req;
    assign dmem_addr   = r_dmem_addr;
    assign dmem_wdata  = r_dmem_wdata;
    assign lsq_head    = 32'(r_head);
    assign lsq_tail    = 32'(r_tail);
    assign lsq_count   = 32'(r_count);

endmodule
